// File: rtl/mont_pkg.sv
// Shared definitions for the word-serial Montgomery multiplier.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package mont_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_B = 3'd1,
    MUL_P = 3'd2,
    SUB   = 3'd3,
    OUT   = 3'd4
  } state_t;

  // ld_sel encodings; 2'b11 addresses nothing.
  localparam logic [1:0] LD_A = 2'b00;
  localparam logic [1:0] LD_B = 2'b01;
  localparam logic [1:0] LD_P = 2'b10;

  // Counter width helper; never returns less than 1 so a counter always exists.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < v) r = k + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mont_word_reg.sv
// N-bit operand register: parallel write, shift-in of a W-bit word at the top, rotate right by W, shift right by 1.
// Latency: one cycle per operation; priority wr > ld > rot > shr1.
// Backpressure: none; every strobe acts in the cycle it is seen.
// Ports: clk, rst (sync, active-high), wr/wdata, ld/din, rot, shr1, q (low OUT_W bits of the register).
module mont_word_reg #(
  parameter int N     = 256,
  parameter int W     = 16,
  parameter int OUT_W = N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [N-1:0]     wdata,
  input  logic             ld,
  input  logic [W-1:0]     din,
  input  logic             rot,
  input  logic             shr1,
  output logic [OUT_W-1:0] q
);

  logic [N-1:0] q_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if (wr) begin
      q_r <= wdata;
    end else if (ld) begin
      q_r <= {din, q_r[N-1:W]};
    end else if (rot) begin
      q_r <= {q_r[W-1:0], q_r[N-1:W]};
    end else if (shr1) begin
      q_r <= {1'b0, q_r[N-1:1]};
    end
  end

  // Only the bits the owner consumes leave the module.
  assign q = q_r[OUT_W-1:0];

endmodule

// File: rtl/mont_mul_ws.sv
// Word-serial radix-2 Montgomery multiplier: R = A*B*2^-N mod P (P odd), one W-bit adder.
// Latency: busy for 2NK+2K cycles after start; result words in the last K of them, done with the last word.
// Backpressure: none; start/ld_valid are ignored while busy, result words are not held.
// Ports: clk, rst (sync, active-high); din/ld_valid/ld_sel load A/B/P LS word first;
//        start/busy/done/err handshake; dout/dout_valid stream the result LS word first.
module mont_mul_ws #(
  parameter int N = 256,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         ld_valid,
  input  logic [1:0]   ld_sel,
  input  logic         start,
  output logic         busy,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         done,
  output logic         err
);
  import mont_pkg::*;

  localparam int K  = N / W;
  localparam int JW = clog2(K);
  localparam int IW = clog2(N);

  state_t state_q, state_d;

  logic [JW-1:0] j_q;
  logic [IW-1:0] i_q;
  logic          carry_q;
  logic          q_q;
  logic [1:0]    ext_q;
  logic [N-1:0]  d_q;
  logic          err_q;

  logic          a_lsb;
  logic [W-1:0]  b_lo;
  logic [W-1:0]  p_lo;
  logic [N-1:0]  c_q;

  // Control strobes
  logic          start_ok, err_d;
  logic          a_ld, b_ld, p_ld, a_shr, b_rot, p_rot;
  logic          c_wr, c_ld, c_rot;
  logic [N-1:0]  c_wdata;

  // Adder
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W:0]    sum;
  logic [1:0]    ext_sum;
  logic [N-1:0]  c_rot_sum;
  logic [N-1:0]  d_next;
  logic          last_word, last_bit, q_eff, no_borrow;

  assign last_word = (j_q == JW'(K - 1));
  assign last_bit  = (i_q == IW'(N - 1));

  // q is taken from C[0] on the first MUL_P word, before any P is added.
  assign q_eff = (j_q == '0) ? c_q[0] : q_q;

  assign sum       = {1'b0, c_q[W-1:0]} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign ext_sum   = ext_q + {1'b0, sum[W]};
  assign c_rot_sum = {sum[W-1:0], c_q[N-1:W]};
  assign d_next    = {sum[W-1:0], d_q[N-1:W]};
  // ~P extends with ones above bit N-1, so {ext,C} - P borrows only if ext and the last carry are both zero.
  assign no_borrow = (ext_q != 2'b00) || sum[W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    err_d    = 1'b0;
    a_ld     = 1'b0;
    b_ld     = 1'b0;
    p_ld     = 1'b0;
    a_shr    = 1'b0;
    b_rot    = 1'b0;
    p_rot    = 1'b0;
    c_wr     = 1'b0;
    c_ld     = 1'b0;
    c_rot    = 1'b0;
    c_wdata  = '0;
    add_b    = '0;
    add_cin  = carry_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Loads presented alongside start are dropped either way.
          if (p_lo[0]) begin
            start_ok = 1'b1;
            c_wr     = 1'b1;
            state_d  = MUL_B;
          end else begin
            err_d = 1'b1;
          end
        end else if (ld_valid) begin
          a_ld = (ld_sel == LD_A);
          b_ld = (ld_sel == LD_B);
          p_ld = (ld_sel == LD_P);
        end
      end
      MUL_B: begin
        add_b = a_lsb ? b_lo : '0;
        c_ld  = 1'b1;
        b_rot = 1'b1;
        p_rot = 1'b1;
        if (last_word) state_d = MUL_P;
      end
      MUL_P: begin
        add_b = q_eff ? p_lo : '0;
        p_rot = 1'b1;
        if (last_word) begin
          // Fold the final word and carry in, then halve {ext, C}.
          c_wr    = 1'b1;
          c_wdata = {ext_sum[0], c_rot_sum[N-1:1]};
          a_shr   = 1'b1;
          state_d = last_bit ? SUB : MUL_B;
        end else begin
          c_ld = 1'b1;
        end
      end
      SUB: begin
        add_b = ~p_lo;
        if (j_q == '0) add_cin = 1'b1;
        p_rot = 1'b1;
        if (last_word && no_borrow) begin
          c_wr    = 1'b1;
          c_wdata = d_next;
        end else begin
          c_rot = 1'b1;
        end
        if (last_word) state_d = OUT;
      end
      OUT: begin
        c_rot = 1'b1;
        if (last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      j_q     <= '0;
      i_q     <= '0;
      carry_q <= 1'b0;
      q_q     <= 1'b0;
      ext_q   <= 2'b00;
      d_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      if (start_ok) begin
        j_q     <= '0;
        i_q     <= '0;
        carry_q <= 1'b0;
        ext_q   <= 2'b00;
      end else if (state_q != IDLE) begin
        j_q     <= last_word ? '0 : j_q + 1'b1;
        carry_q <= last_word ? 1'b0 : sum[W];
        if (state_q == MUL_P && j_q == '0) q_q <= c_q[0];
        if (state_q == MUL_B && last_word) ext_q <= ext_sum;
        if (state_q == MUL_P && last_word) begin
          ext_q <= {1'b0, ext_sum[1]};
          i_q   <= last_bit ? '0 : i_q + 1'b1;
        end
        if (state_q == SUB) d_q <= d_next;
        if (state_q == SUB && last_word) ext_q <= 2'b00;
      end
    end
  end

  mont_word_reg #(.N(N), .W(W), .OUT_W(1)) u_a (
    .clk(clk), .rst(rst), .wr(1'b0), .wdata('0), .ld(a_ld), .din(din),
    .rot(1'b0), .shr1(a_shr), .q(a_lsb)
  );

  mont_word_reg #(.N(N), .W(W), .OUT_W(W)) u_b (
    .clk(clk), .rst(rst), .wr(1'b0), .wdata('0), .ld(b_ld), .din(din),
    .rot(b_rot), .shr1(1'b0), .q(b_lo)
  );

  mont_word_reg #(.N(N), .W(W), .OUT_W(W)) u_p (
    .clk(clk), .rst(rst), .wr(1'b0), .wdata('0), .ld(p_ld), .din(din),
    .rot(p_rot), .shr1(1'b0), .q(p_lo)
  );

  mont_word_reg #(.N(N), .W(W), .OUT_W(N)) u_c (
    .clk(clk), .rst(rst), .wr(c_wr), .wdata(c_wdata), .ld(c_ld), .din(sum[W-1:0]),
    .rot(c_rot), .shr1(1'b0), .q(c_q)
  );

  assign busy       = (state_q != IDLE);
  assign dout_valid = (state_q == OUT);
  assign dout       = dout_valid ? c_q[W-1:0] : '0;
  assign done       = err_q || ((state_q == OUT) && last_word);
  assign err        = err_q;

endmodule

// File: tb/tb_mont_mul_ws.sv
module tb_mont_mul_ws;
  import mont_pkg::*;

  localparam int N = 32;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         ld_valid;
  logic [1:0]   ld_sel;
  logic         start;
  logic         busy;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         done;
  logic         err;

  int total = 0;
  int bad   = 0;

  // Results of the latest run_op
  int           cyc, done_cyc, fall_cyc, first_dv, nwords;
  logic [W-1:0] w0, w1;
  logic         saw_err, busy1;

  mont_mul_ws #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .ld_valid(ld_valid), .ld_sel(ld_sel),
    .start(start), .busy(busy), .dout(dout), .dout_valid(dout_valid),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic load_reg(input logic [1:0] sel, input logic [31:0] v);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ld_sel   = sel;
      din      = v[k*16 +: 16];
      ld_valid = 1'b1;
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // Start is sampled in cycle 0; each loop pass observes cycle cyc at its falling edge.
  task automatic run_op(input int inj_cyc, input int rst_cyc);
    @(negedge clk);
    start    = 1'b1;
    cyc      = 0;
    done_cyc = -1;
    fall_cyc = -1;
    first_dv = -1;
    nwords   = 0;
    w0       = '0;
    w1       = '0;
    saw_err  = 1'b0;
    busy1    = 1'b0;
    while (cyc < 300 && fall_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        busy1 = busy;
      end
      if (dout_valid) begin
        if (nwords == 0) begin
          first_dv = cyc;
          w0       = dout;
        end else if (nwords == 1) begin
          w1 = dout;
        end
        nwords++;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (err) saw_err = 1'b1;
      if (!busy) fall_cyc = cyc;
      if (cyc == inj_cyc) begin
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_sel   = LD_P;
        din      = 16'h0009;
      end
      if (cyc == inj_cyc + 1) begin
        start    = 1'b0;
        ld_valid = 1'b0;
      end
      if (cyc == rst_cyc) rst = 1'b1;
      if (cyc == rst_cyc + 1) rst = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    din      = '0;
    ld_valid = 1'b0;
    ld_sel   = 2'b11;
    start    = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, dout_valid, done, err, dout} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h exp=0", {busy, dout_valid, done, err, dout});
    end
    total++;
    if (dut.c_q !== '0) begin
      bad++;
      $display("FAIL reset_c got=%0h exp=0", dut.c_q);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    load_reg(LD_A, 32'd3);
    load_reg(LD_B, 32'd5);
    load_reg(LD_P, 32'd7);
    run_op(-10, -10);
    total++;
    if (busy1 !== 1'b1) begin bad++; $display("FAIL basic_busy1 got=%0b exp=1", busy1); end
    total++;
    if ({w1, w0} !== 32'h0000_0002) begin bad++; $display("FAIL basic_result got=%0h exp=2", {w1, w0}); end
    total++;
    if (nwords !== 2) begin bad++; $display("FAIL basic_nwords got=%0d exp=2", nwords); end
    total++;
    if (first_dv !== 131) begin bad++; $display("FAIL basic_first_word got=%0d exp=131", first_dv); end
    total++;
    if (done_cyc !== 132) begin bad++; $display("FAIL basic_done got=%0d exp=132", done_cyc); end
    total++;
    if (fall_cyc !== 133) begin bad++; $display("FAIL basic_busy_fall got=%0d exp=133", fall_cyc); end
  endtask

  task automatic test_zero_a;
    load_reg(LD_A, 32'd0);
    load_reg(LD_B, 32'd5);
    load_reg(LD_P, 32'd7);
    run_op(-10, -10);
    total++;
    if ({w1, w0} !== 32'h0) begin bad++; $display("FAIL zero_result got=%0h exp=0", {w1, w0}); end
    total++;
    if (done_cyc !== 132) begin bad++; $display("FAIL zero_done got=%0d exp=132", done_cyc); end
  endtask

  task automatic test_err;
    load_reg(LD_P, 32'd8);
    run_op(-10, -10);
    total++;
    if (done_cyc !== 1) begin bad++; $display("FAIL err_done got=%0d exp=1", done_cyc); end
    total++;
    if (saw_err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%0b exp=1", saw_err); end
    total++;
    if (nwords !== 0) begin bad++; $display("FAIL err_nwords got=%0d exp=0", nwords); end
    total++;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL err_busy got=%0b exp=0", busy1); end
    @(negedge clk);
    total++;
    if ({err, done} !== 2'b00) begin bad++; $display("FAIL err_one_cycle got=%0b exp=00", {err, done}); end
    // B=5 must have survived the rejected start.
    load_reg(LD_P, 32'd7);
    load_reg(LD_A, 32'd3);
    run_op(-10, -10);
    total++;
    if ({w1, w0} !== 32'h0000_0002) begin bad++; $display("FAIL err_retained got=%0h exp=2", {w1, w0}); end
  endtask

  task automatic test_big;
    load_reg(LD_A, 32'hFFFF_FFFE);
    load_reg(LD_B, 32'hFFFF_FFFE);
    load_reg(LD_P, 32'hFFFF_FFFF);
    run_op(-10, -10);
    total++;
    if ({w1, w0} !== 32'h0000_0001) begin bad++; $display("FAIL big_result got=%0h exp=1", {w1, w0}); end
    total++;
    if (done_cyc !== 132) begin bad++; $display("FAIL big_done got=%0d exp=132", done_cyc); end
  endtask

  task automatic test_ignore_busy;
    load_reg(LD_A, 32'd3);
    load_reg(LD_B, 32'd5);
    load_reg(LD_P, 32'd7);
    run_op(20, -10);
    total++;
    if ({w1, w0} !== 32'h0000_0002) begin bad++; $display("FAIL ignore_result got=%0h exp=2", {w1, w0}); end
    total++;
    if (fall_cyc !== 133) begin bad++; $display("FAIL ignore_busy_fall got=%0d exp=133", fall_cyc); end
  endtask

  task automatic test_back_to_back;
    // A is consumed by the previous run; B and P should come back intact.
    load_reg(LD_A, 32'd3);
    run_op(-10, -10);
    total++;
    if ({w1, w0} !== 32'h0000_0002) begin bad++; $display("FAIL b2b_result got=%0h exp=2", {w1, w0}); end
    total++;
    if (done_cyc !== 132) begin bad++; $display("FAIL b2b_done got=%0d exp=132", done_cyc); end
  endtask

  task automatic test_mid_reset;
    load_reg(LD_A, 32'd3);
    load_reg(LD_B, 32'd5);
    load_reg(LD_P, 32'd7);
    run_op(-10, 50);
    total++;
    if (fall_cyc !== 51) begin bad++; $display("FAIL rst_busy_fall got=%0d exp=51", fall_cyc); end
    total++;
    if (nwords !== 0) begin bad++; $display("FAIL rst_nwords got=%0d exp=0", nwords); end
    total++;
    if ({dut.c_q, dut.u_a.q_r, dut.ext_q} !== '0) begin
      bad++;
      $display("FAIL rst_regs got=%0h exp=0", {dut.c_q, dut.u_a.q_r, dut.ext_q});
    end
    // P was cleared to zero, so an immediate start must be rejected.
    run_op(-10, -10);
    total++;
    if (saw_err !== 1'b1) begin bad++; $display("FAIL rst_p_cleared got=%0b exp=1", saw_err); end
    load_reg(LD_A, 32'd3);
    load_reg(LD_B, 32'd5);
    load_reg(LD_P, 32'd7);
    run_op(-10, -10);
    total++;
    if ({w1, w0} !== 32'h0000_0002) begin bad++; $display("FAIL rst_rerun_result got=%0h exp=2", {w1, w0}); end
    total++;
    if (done_cyc !== 132) begin bad++; $display("FAIL rst_rerun_done got=%0d exp=132", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_a();
    test_err();
    test_big();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mont_mul_ws.md
Name: mont_mul_ws

Overview:
- Parametrised word-serial radix-2 Montgomery multiplier. Computes R = A·B·2^-N mod P for odd P.
- Operands load W bits at a time; the result reads out W bits at a time.
- Owns its control FSM and start/busy/done handshake, so the top level only sequences loads and reads.
- Generalises the fixed 256/16 datapath to any N and W.

Parameters:
- N, 256, operand/modulus width in bits; N % W == 0, N >= 2·W.
- W, 16, datapath/adder word width in bits.
- K (localparam), N/W, words per operand.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  W  operand load word.
- ld_valid  in  1  load strobe for din.
- ld_sel  in  2  target register: 00 = A, 01 = B, 10 = P, 11 = ignored.
- start  in  1  begin multiplication.
- busy  out  1  operation in progress.
- dout  out  W  result word, LS word first.
- dout_valid  out  1  dout carries a result word.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse: P even at start.

Behaviour:
- Reset: FSM goes to IDLE. busy, dout_valid, done and err are 0; dout is 0. A, B, P, C, D, ext, carry and counters are all cleared. Reset applies mid-operation and has priority over everything else.
- Load, IDLE only: on ld_valid, the selected register shifts right by W and din enters the top word. K loads, LS word first, fill the register. ld_valid is ignored while busy, or in the same cycle as an accepted start.
- Start: accepted only in IDLE. If start arrives while busy, it is ignored.
  - P[0] == 0 at start: err and done pulse in the next cycle. No dout words, state stays IDLE, operands are retained.
- States: IDLE -> MUL_B -> MUL_P -> (MUL_B | SUB) -> OUT -> IDLE.
- Datapath: one W-bit adder, carry flop, word counter j (0..K-1), bit counter i (0..N-1). C is an N-bit register plus a 2-bit extension ext.
- MUL_B, K cycles: C_j += (A[0] ? B_j : 0) + carry. C, B and P rotate right by W each cycle. In the last cycle the carry-out is added into ext.
- MUL_P, K cycles: q = C[0] is latched on entry. C_j += (q ? P_j : 0) + carry.
  - Last cycle: {ext, C} shifts right by 1 and A shifts right by 1.
  - If i == N-1, go to SUB; otherwise i++ and go to MUL_B.
- Invariant: C < 2P after each iteration; ext is never more than 1 after the shift.
- SUB, K cycles: D = {ext, C} − P, computed as an add of ~P with carry-in 1 on word 0. On exit, D replaces C if there is no final borrow; otherwise C is kept.
- OUT, K cycles: dout_valid = 1, dout = C word j. done is high in the same cycle as the last word.
- Latency, with start sampled in cycle 0:
  - busy is high in cycles 1 .. 2NK+2K.
  - dout words appear in cycles 2NK+K+1 .. 2NK+2K.
  - done is high in cycle 2NK+2K.
  - A new start is accepted in cycle 2NK+2K+1.
- Inputs A and B must be < P for the R < P guarantee. The A value is consumed by the operation; B and P are preserved, since their rotations return to the original alignment.
- Width rules: adder is W+1 bits; ext is 2 bits; the sum never overflows given the invariant.

Decomposition:
- Shared package mont_pkg holds:
  - the state enum (IDLE, MUL_B, MUL_P, SUB, OUT);
  - the ld_sel encodings LD_A, LD_B, LD_P;
  - a clog2 helper for the counter widths.
- One sub-module: mont_word_reg, a parametrised N-bit register with load-shift-in and cyclic rotate-by-W. It is instantiated for A (which needs an extra shift-by-1 mode), B, P and C.
- The adder and FSM stay in the top level.

Test Plan:
- N=32, W=16. Load A=3, B=5, P=7, then start → dout words 0x0002, 0x0000; done in cycle 132; busy falls in cycle 133.
- N=32. Load A=0, B=5, P=7 → result 0; latency identical to the previous test (132).
- N=32. Load A=B=0xFFFFFFFE, P=0xFFFFFFFF → result 0x00000001. This exercises ext and the SUB borrow path.
- N=32. P=0x00000008, start → err=1 and done=1 in cycle 1; dout_valid stays 0; busy stays 0.
- N=32. Start with 3/5/7; pulse start and ld_valid with ld_sel=LD_P, din=0x0009 at cycle 20 → both ignored, result still 2.
- N=32. Assert rst at cycle 50 → busy=0 at cycle 51, all registers 0. Reload 3/5/7 and start → result 2 with nominal latency.
